// File: rtl/request_encoder.sv
// -----------------------------------------------------------------------------
// request_encoder
//
// Purpose:
//   16-to-4 registered priority encoder. Request pulses on encoder_in are
//   merged into a pending register; one pending index at a time is offered on
//   encoder_out over a valid/ready handshake and its pending bit is cleared
//   when the consumer accepts it. Back-to-back transfers run at one per cycle.
//
// Configuration macro:
//   ROUND_ROBIN_EN  undefined -> fixed priority, lowest set index wins.
//                   defined   -> round-robin search upward from rr_ptr,
//                                wrapping 15 -> 0; rr_ptr advances to
//                                encoder_out + 1 on every accepted transfer.
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   enable       in   1      1 = capture encoder_in into pending
//   encoder_in   in   16     request vector, any number of bits per cycle
//   encoder_out  out  4      granted index, meaningful while out_valid=1
//   out_valid    out  1      encoder_out holds a pending index
//   out_ready    in   1      consumer accepts encoder_out this cycle
//   pending      out  16     pending-request register
//   overflow     out  1      sticky while enable=1: request hit a pending bit
// -----------------------------------------------------------------------------
module request_encoder #(
  parameter int N_REQ = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_REQ-1:0] encoder_in,
  output logic [IDX_W-1:0] encoder_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_REQ-1:0] pending,
  output logic             overflow
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [N_REQ-1:0] r_pending;
  logic [N_REQ-1:0] w_pending_next;
  logic [N_REQ-1:0] w_clr;
  logic [N_REQ-1:0] w_new;
  logic [N_REQ-1:0] w_remain;

  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_sel_any;

  logic             w_xfer;
  logic             w_dup;
  logic             r_overflow;
  logic             w_overflow_next;

  // ---------------------------------------------------------------------------
  // Index selection functions
  // ---------------------------------------------------------------------------

  // Lowest set index; returns 0 when vec is empty (caller gates with w_sel_any).
  function automatic logic [IDX_W-1:0] f_sel_low(input logic [N_REQ-1:0] vec);
    logic [IDX_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && vec[k]) begin
        idx   = IDX_W'(k);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

`ifdef ROUND_ROBIN_EN
  // First set index at or above ptr, wrapping. N_REQ is a power of two, so
  // the IDX_W-bit add wraps 15 -> 0 on its own.
  function automatic logic [IDX_W-1:0] f_sel_rr(input logic [N_REQ-1:0] vec,
                                                input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cand;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && vec[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Handshake and pending-vector datapath
  // ---------------------------------------------------------------------------
  assign out_valid = (r_state == ST_HOLD);
  assign w_xfer    = out_valid & out_ready;

  // Per-bit clear of the accepted index and gated capture of new requests.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_bit
      assign w_clr[gi] = w_xfer & (r_idx == IDX_W'(gi));
      assign w_new[gi] = enable & encoder_in[gi];
    end
  endgenerate

  // The selector only sees what survives the clear; requests arriving this
  // cycle become visible one cycle later. A new request on the bit being
  // cleared simply re-sets it.
  assign w_remain       = r_pending & ~w_clr;
  assign w_pending_next = w_remain | w_new;
  assign w_sel_any      = |w_remain;

  // Duplicate = new request on a bit that stays pending after this cycle's clear.
  assign w_dup           = |(w_new & w_remain);
  assign w_overflow_next = enable ? (r_overflow | w_dup) : 1'b0;

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_rr_ptr;

  assign w_sel_idx = f_sel_rr(w_remain, r_rr_ptr);

  // Pointer starts at 0 so the first grant after reset matches fixed priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= r_idx + 1'b1;
    end
  end
`else
  assign w_sel_idx = f_sel_low(w_remain);
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_any) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Without a transfer the current index is still pending, so the
        // only way out of HOLD is an accept that leaves nothing behind.
        if (w_xfer && !w_sel_any) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next value of the presented index)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_idx_next = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_any) begin
          w_idx_next = w_sel_idx;
        end
      end
      ST_HOLD: begin
        // Held stable under backpressure; on accept either chain straight
        // into the next grant or return the index to zero.
        if (w_xfer) begin
          w_idx_next = w_sel_any ? w_sel_idx : '0;
        end
      end
      default: begin
        w_idx_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_idx      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending  <= w_pending_next;
      r_idx      <= w_idx_next;
      r_overflow <= w_overflow_next;
    end
  end

  assign encoder_out = r_idx;
  assign pending     = r_pending;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_request_encoder.sv
// -----------------------------------------------------------------------------
// tb_request_encoder
//
// Self-checking bench for request_encoder: a table of directed single-cycle
// vectors, a hand-written asynchronous reset sequence, then randomized traffic
// compared cycle by cycle against a behavioural model of the pending set.
// -----------------------------------------------------------------------------
module tb_request_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] encoder_in = '0;
  logic [3:0]  encoder_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] pending;
  logic        overflow;

  always #5 clk = ~clk;

  request_encoder #(
    .N_REQ(16),
    .IDX_W(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .encoder_in (encoder_in),
    .encoder_out(encoder_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pending    (pending),
    .overflow   (overflow)
  );

`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a set of pending request numbers, the offered index,
  // and a search start point.
  // ---------------------------------------------------------------------------
  bit m_pend[16];
  int m_idx;
  bit m_valid;
  bit m_ovf;
  int m_ptr;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
    m_idx = 0; m_valid = 1'b0; m_ovf = 1'b0; m_ptr = 0;
  endtask

  function automatic logic [15:0] m_pend_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_step(input logic en, input logic [15:0] din, input logic rdy);
    bit remain[16];
    bit xfer;
    bit hit;
    int old_idx;
    int start;
    int j;
    xfer    = m_valid && rdy;
    old_idx = m_idx;
    hit     = 1'b0;
    for (int i = 0; i < 16; i++) remain[i] = m_pend[i];
    if (xfer) remain[old_idx] = 1'b0;
    for (int i = 0; i < 16; i++) if (en && din[i] && remain[i]) hit = 1'b1;
    if (!m_valid || xfer) begin
      m_valid = 1'b0;
      m_idx   = 0;
      start   = RR ? m_ptr : 0;
      for (int k = 0; k < 16; k++) begin
        j = (start + k) % 16;
        if (!m_valid && remain[j]) begin
          m_valid = 1'b1;
          m_idx   = j;
        end
      end
    end
    if (xfer) m_ptr = (old_idx + 1) % 16;
    for (int i = 0; i < 16; i++) m_pend[i] = remain[i] | (en & din[i]);
    m_ovf = en ? (m_ovf | hit) : 1'b0;
  endtask

  // Apply inputs for one cycle, advance the model, sample 1 ns after the edge.
  task automatic step(input logic en, input logic [15:0] din, input logic rdy);
    enable     = en;
    encoder_in = din;
    out_ready  = rdy;
    model_step(en, din, rdy);
    @(posedge clk);
    #1;
  endtask

  // Assert reset half a cycle away from any edge; outputs must clear at once.
  task automatic do_reset(input string tag);
    enable     = 1'b0;
    encoder_in = '0;
    out_ready  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({tag, ".encoder_out"}, int'(encoder_out), 0);
    chk({tag, ".out_valid"},   int'(out_valid),   0);
    chk({tag, ".pending"},     int'(pending),     0);
    chk({tag, ".overflow"},    int'(overflow),    0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: inputs held for one cycle, outputs expected after it.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        en;
    logic [15:0] din;
    logic        rdy;
    logic [3:0]  e_out;
    logic        e_valid;
    logic [15:0] e_pend;
    logic        e_ovf;
  } vec_t;

  localparam int N_VEC = 28;
  vec_t tbl[N_VEC];

  initial begin
    // single request
    tbl[0]  = '{1'b1, 16'h0010, 1'b1, 4'd0,  1'b0, 16'h0010, 1'b0};
    tbl[1]  = '{1'b1, 16'h0000, 1'b1, 4'd4,  1'b1, 16'h0010, 1'b0};
    tbl[2]  = '{1'b1, 16'h0000, 1'b1, 4'd0,  1'b0, 16'h0000, 1'b0};
    // backpressure then a back-to-back drain
    tbl[3]  = '{1'b1, 16'h8421, 1'b0, 4'd0,  1'b0, 16'h8421, 1'b0};
    tbl[4]  = '{1'b1, 16'h0000, 1'b0, 4'd0,  1'b1, 16'h8421, 1'b0};
    tbl[5]  = '{1'b1, 16'h0000, 1'b0, 4'd0,  1'b1, 16'h8421, 1'b0};
    tbl[6]  = '{1'b1, 16'h0000, 1'b0, 4'd0,  1'b1, 16'h8421, 1'b0};
    tbl[7]  = '{1'b1, 16'h0000, 1'b0, 4'd0,  1'b1, 16'h8421, 1'b0};
    tbl[8]  = '{1'b1, 16'h0000, 1'b1, 4'd5,  1'b1, 16'h8420, 1'b0};
    tbl[9]  = '{1'b1, 16'h0000, 1'b1, 4'd10, 1'b1, 16'h8400, 1'b0};
    tbl[10] = '{1'b1, 16'h0000, 1'b1, 4'd15, 1'b1, 16'h8000, 1'b0};
    tbl[11] = '{1'b1, 16'h0000, 1'b1, 4'd0,  1'b0, 16'h0000, 1'b0};
    // duplicate request raises overflow, enable=0 clears it, draining continues
    tbl[12] = '{1'b1, 16'h0008, 1'b0, 4'd0,  1'b0, 16'h0008, 1'b0};
    tbl[13] = '{1'b1, 16'h0008, 1'b0, 4'd3,  1'b1, 16'h0008, 1'b1};
    tbl[14] = '{1'b1, 16'h0000, 1'b0, 4'd3,  1'b1, 16'h0008, 1'b1};
    tbl[15] = '{1'b0, 16'h0000, 1'b0, 4'd3,  1'b1, 16'h0008, 1'b0};
    // clear and re-request of the same bit in one cycle
    tbl[16] = '{1'b1, 16'h0004, 1'b1, 4'd0,  1'b0, 16'h0004, 1'b0};
    tbl[17] = '{1'b1, 16'h0000, 1'b0, 4'd2,  1'b1, 16'h0004, 1'b0};
    tbl[18] = '{1'b1, 16'h0004, 1'b1, 4'd0,  1'b0, 16'h0004, 1'b0};
    tbl[19] = '{1'b1, 16'h0000, 1'b0, 4'd2,  1'b1, 16'h0004, 1'b0};
    tbl[20] = '{1'b1, 16'h0000, 1'b1, 4'd0,  1'b0, 16'h0000, 1'b0};
    // constant 0x0003: the just-accepted bit is masked from re-selection, so
    // grants alternate 0,1,0,1; the repeated requests set overflow
    tbl[21] = '{1'b1, 16'h0003, 1'b1, 4'd0,  1'b0, 16'h0003, 1'b0};
    tbl[22] = '{1'b1, 16'h0003, 1'b1, 4'd0,  1'b1, 16'h0003, 1'b1};
    tbl[23] = '{1'b1, 16'h0003, 1'b1, 4'd1,  1'b1, 16'h0003, 1'b1};
    tbl[24] = '{1'b1, 16'h0003, 1'b1, 4'd0,  1'b1, 16'h0003, 1'b1};
    tbl[25] = '{1'b1, 16'h0003, 1'b1, 4'd1,  1'b1, 16'h0003, 1'b1};
    tbl[26] = '{1'b1, 16'h0000, 1'b1, 4'd0,  1'b1, 16'h0001, 1'b1};
    tbl[27] = '{1'b1, 16'h0000, 1'b1, 4'd0,  1'b0, 16'h0000, 1'b1};
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] din;
    logic        en;
    logic        rdy;

    #2;
    model_reset();
    do_reset("reset_init");

    // directed table
    for (int v = 0; v < N_VEC; v++) begin
      step(tbl[v].en, tbl[v].din, tbl[v].rdy);
      $display("vec %0d: en=%0b in=%h rdy=%0b -> out=%0d valid=%0b pend=%h ovf=%0b",
               v, tbl[v].en, tbl[v].din, tbl[v].rdy, encoder_out, out_valid, pending, overflow);
      chk($sformatf("vec%0d.encoder_out", v), int'(encoder_out), int'(tbl[v].e_out));
      chk($sformatf("vec%0d.out_valid", v),   int'(out_valid),   int'(tbl[v].e_valid));
      chk($sformatf("vec%0d.pending", v),     int'(pending),     int'(tbl[v].e_pend));
      chk($sformatf("vec%0d.overflow", v),    int'(overflow),    int'(tbl[v].e_ovf));
    end

    // asynchronous reset while an index is held under backpressure
    step(1'b1, 16'h00F0, 1'b0);
    chk("midhold.pending", int'(pending), 16'h00F0);
    step(1'b1, 16'h0000, 1'b0);
    chk("midhold.out_valid",   int'(out_valid),   1);
    chk("midhold.encoder_out", int'(encoder_out), 4);
    chk("midhold.overflow",    int'(overflow),    1);
    do_reset("reset_midhold");
    step(1'b0, 16'h0000, 1'b1);
    chk("post_reset.out_valid", int'(out_valid), 0);
    chk("post_reset.pending",   int'(pending),   0);
    $display("midhold reset: pending dropped, out_valid=%0b", out_valid);

    // randomized traffic against the model
    do_reset("reset_rand");
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset("reset_rand_mid");
        $display("rand %0d: reset", c);
      end
      en  = ($urandom_range(0, 7) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       din = 16'h0000;
        1:       din = 16'(32'd1 << $urandom_range(0, 15));
        2:       din = 16'($urandom & $urandom & $urandom);
        default: din = 16'($urandom);
      endcase
      step(en, din, rdy);
      $display("rand %0d: en=%0b in=%h rdy=%0b -> out=%0d valid=%0b pend=%h ovf=%0b",
               c, en, din, rdy, encoder_out, out_valid, pending, overflow);
      chk("rand.encoder_out", int'(encoder_out), m_idx);
      chk("rand.out_valid",   int'(out_valid),   int'(m_valid));
      chk("rand.pending",     int'(pending),     int'(m_pend_vec()));
      chk("rand.overflow",    int'(overflow),    int'(m_ovf));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
